// File: rtl/encoder_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// encoder_cmd_sequencer
//
// Synchronous command front-end for an asynchronous 32-bit incremental
// encoder counter. Turns host commands into safely timed accesses on the
// counter's shared DataBus / SetCPR / SetPosition / EnableIndex controls.
// One command is in flight at a time.
//
// Optional feature macro: ENCODER_HOME_TIMEOUT_EN
//   defined   : HOME gives up after HOME_TIMEOUT_CYCLES and answers with
//               RspError=1.
//   undefined : HOME waits for an index edge indefinitely (only reset
//               exits) and no timeout counter is built.
//
// Ports:
//   i_clock          system clock, rising edge
//   i_reset          asynchronous, active-high reset
//   i_cmd_valid      command request
//   o_cmd_ready      block idle; command accepted on i_cmd_valid && o_cmd_ready
//   i_cmd_op         00 SET_CPR, 01 SET_POS, 10 HOME, 11 READ_POS
//   i_cmd_data       payload for SET_CPR / SET_POS
//   o_rsp_valid      one-cycle completion pulse, no backpressure
//   o_rsp_data       written value, 0 for HOME, sampled position for READ_POS
//   o_rsp_error      qualifies o_rsp_valid: timeout or unstable read
//   o_data_bus       counter data bus
//   o_set_cpr        counter CPR load strobe
//   o_set_position   counter position load strobe
//   o_enable_index   counter index enable
//   i_index          raw index channel I (asynchronous)
//   i_position       counter position (asynchronous to i_clock)
//   o_state          current FSM state (debug)
//
// Handshake: a command transfers on a rising edge where i_cmd_valid and
// o_cmd_ready are both 1. The requester holds op/data stable until then;
// i_cmd_valid while busy is ignored. o_rsp_valid has no ready; it pulses
// for exactly one cycle and never coincides with o_cmd_ready.
// ---------------------------------------------------------------------------
module encoder_cmd_sequencer #(
    parameter int BUSWIDTH            = 32,
    parameter int SETUP_CYCLES        = 2,
    parameter int STROBE_CYCLES       = 2,
    parameter int HOLD_CYCLES         = 2,
    parameter int READ_RETRIES        = 4,
    parameter int HOME_TIMEOUT_CYCLES = 1000000
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_cmd_valid,
    output logic                o_cmd_ready,
    input  logic [1:0]          i_cmd_op,
    input  logic [BUSWIDTH-1:0] i_cmd_data,
    output logic                o_rsp_valid,
    output logic [BUSWIDTH-1:0] o_rsp_data,
    output logic                o_rsp_error,
    output logic [BUSWIDTH-1:0] o_data_bus,
    output logic                o_set_cpr,
    output logic                o_set_position,
    output logic                o_enable_index,
    input  logic                i_index,
    input  logic [BUSWIDTH-1:0] i_position,
    output logic [2:0]          o_state
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_SETUP     = 3'd1;
    localparam logic [2:0] S_STROBE    = 3'd2;
    localparam logic [2:0] S_HOLD      = 3'd3;
    localparam logic [2:0] S_HOME_WAIT = 3'd4;
    localparam logic [2:0] S_READ_A    = 3'd5;
    localparam logic [2:0] S_READ_B    = 3'd6;
    localparam logic [2:0] S_RESP      = 3'd7;

    localparam logic [1:0] OP_SET_CPR  = 2'b00;
    localparam logic [1:0] OP_SET_POS  = 2'b01;
    localparam logic [1:0] OP_HOME     = 2'b10;

    // Phase counters load N-1 and count down to 0, so a phase lasts N cycles.
    localparam logic [7:0] SETUP_LD  = 8'(SETUP_CYCLES - 1);
    localparam logic [7:0] STROBE_LD = 8'(STROBE_CYCLES - 1);
    localparam logic [7:0] HOLD_LD   = 8'(HOLD_CYCLES - 1);
    localparam logic [3:0] RETRY_MAX = 4'(READ_RETRIES);

`ifdef ENCODER_HOME_TIMEOUT_EN
    localparam int               TO_W    = $clog2(HOME_TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(HOME_TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0]             r_to_cnt;
`endif

    logic [2:0]          r_state;
    logic                r_cmd_ready;
    logic [1:0]          r_op;
    logic [7:0]          r_cnt;
    logic [3:0]          r_retry;
    logic                r_cmp;
    logic [BUSWIDTH-1:0] r_s0;
    logic [BUSWIDTH-1:0] r_s1;
    logic                r_idx_meta;
    logic                r_idx_sync;
    logic                r_idx_prev;
    logic                r_rsp_valid;
    logic [BUSWIDTH-1:0] r_rsp_data;
    logic                r_rsp_error;
    logic [BUSWIDTH-1:0] r_data_bus;
    logic                r_set_cpr;
    logic                r_set_position;
    logic                r_enable_index;
    logic                w_idx_rise;

    // Edge between two consecutive synchronized samples. A level that is
    // already high when HOME starts never produces this, so a fresh 0->1
    // transition is required.
    assign w_idx_rise = r_idx_sync & ~r_idx_prev;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state        <= S_IDLE;
            r_cmd_ready    <= 1'b0;
            r_op           <= 2'b00;
            r_cnt          <= 8'd0;
            r_retry        <= 4'd0;
            r_cmp          <= 1'b0;
            r_s0           <= '0;
            r_s1           <= '0;
            r_idx_meta     <= 1'b0;
            r_idx_sync     <= 1'b0;
            r_idx_prev     <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_data     <= '0;
            r_rsp_error    <= 1'b0;
            r_data_bus     <= '0;
            r_set_cpr      <= 1'b0;
            r_set_position <= 1'b0;
            r_enable_index <= 1'b0;
`ifdef ENCODER_HOME_TIMEOUT_EN
            r_to_cnt       <= '0;
`endif
        end else begin
            r_idx_meta <= i_index;
            r_idx_sync <= r_idx_meta;
            r_idx_prev <= r_idx_sync;

            case (r_state)
                S_IDLE: begin
                    if (r_cmd_ready && i_cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_op        <= i_cmd_op;
                        r_retry     <= 4'd0;
                        r_cmp       <= 1'b0;
                        case (i_cmd_op)
                            OP_SET_CPR, OP_SET_POS: begin
                                r_data_bus <= i_cmd_data;
                                r_cnt      <= SETUP_LD;
                                r_state    <= S_SETUP;
                            end
                            OP_HOME: begin
                                r_enable_index <= 1'b1;
                                r_state        <= S_HOME_WAIT;
`ifdef ENCODER_HOME_TIMEOUT_EN
                                r_to_cnt       <= '0;
`endif
                            end
                            default: r_state <= S_READ_A;
                        endcase
                    end else begin
                        r_cmd_ready <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= S_STROBE;
                        r_cnt   <= STROBE_LD;
                        if (r_op == OP_SET_POS) r_set_position <= 1'b1;
                        else                    r_set_cpr      <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_STROBE: begin
                    if (r_cnt == 8'd0) begin
                        r_state        <= S_HOLD;
                        r_cnt          <= HOLD_LD;
                        r_set_cpr      <= 1'b0;
                        r_set_position <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == 8'd0) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= r_data_bus;
                        r_rsp_error <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                S_HOME_WAIT: begin
                    // Edge is tested first so an edge landing on the expiry
                    // cycle still counts as a successful home.
                    if (w_idx_rise) begin
                        r_enable_index <= 1'b0;
                        r_state        <= S_RESP;
                        r_rsp_valid    <= 1'b1;
                        r_rsp_data     <= '0;
                        r_rsp_error    <= 1'b0;
                    end
`ifdef ENCODER_HOME_TIMEOUT_EN
                    else if (r_to_cnt == TO_LAST) begin
                        r_enable_index <= 1'b0;
                        r_state        <= S_RESP;
                        r_rsp_valid    <= 1'b1;
                        r_rsp_data     <= '0;
                        r_rsp_error    <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
`endif
                end
                S_READ_A: begin
                    r_s0    <= i_position;
                    r_state <= S_READ_B;
                end
                S_READ_B: begin
                    // Alternates capture and compare so the comparison works
                    // on registered samples, never on the live async bus.
                    if (!r_cmp) begin
                        r_s1  <= i_position;
                        r_cmp <= 1'b1;
                    end else if (r_s0 == r_s1) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= r_s1;
                        r_rsp_error <= 1'b0;
                    end else if (r_retry == RETRY_MAX) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= r_s1;
                        r_rsp_error <= 1'b1;
                    end else begin
                        r_s0    <= r_s1;
                        r_retry <= r_retry + 4'd1;
                        r_cmp   <= 1'b0;
                    end
                end
                S_RESP: begin
                    r_rsp_valid <= 1'b0;
                    r_rsp_error <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_cmd_ready    = r_cmd_ready;
    assign o_rsp_valid    = r_rsp_valid;
    assign o_rsp_data     = r_rsp_data;
    assign o_rsp_error    = r_rsp_error;
    assign o_data_bus     = r_data_bus;
    assign o_set_cpr      = r_set_cpr;
    assign o_set_position = r_set_position;
    assign o_enable_index = r_enable_index;
    assign o_state        = r_state;

endmodule

// File: tb/tb_encoder_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_encoder_cmd_sequencer
//
// Self-checking bench for encoder_cmd_sequencer. Cycle k of a command is the
// clock period following the accept edge (k=0 is the first period after it).
// Inputs change and outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_encoder_cmd_sequencer;

    localparam int BW = 32;
    localparam logic [1:0] OP_SET_CPR = 2'b00;
    localparam logic [1:0] OP_SET_POS = 2'b01;
    localparam logic [1:0] OP_HOME    = 2'b10;
    localparam logic [1:0] OP_READ    = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_cmd_valid;
    logic          o_cmd_ready;
    logic [1:0]    i_cmd_op;
    logic [BW-1:0] i_cmd_data;
    logic          o_rsp_valid;
    logic [BW-1:0] o_rsp_data;
    logic          o_rsp_error;
    logic [BW-1:0] o_data_bus;
    logic          o_set_cpr;
    logic          o_set_position;
    logic          o_enable_index;
    logic          i_index;
    logic [BW-1:0] i_position;
    logic [2:0]    o_state;

    int n_checks = 0;
    int n_fail   = 0;

    // {error, data}
    logic [BW:0] exp_q[$];

    encoder_cmd_sequencer #(
        .BUSWIDTH(BW),
        .HOME_TIMEOUT_CYCLES(50)
    ) dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_cmd_valid   (i_cmd_valid),
        .o_cmd_ready   (o_cmd_ready),
        .i_cmd_op      (i_cmd_op),
        .i_cmd_data    (i_cmd_data),
        .o_rsp_valid   (o_rsp_valid),
        .o_rsp_data    (o_rsp_data),
        .o_rsp_error   (o_rsp_error),
        .o_data_bus    (o_data_bus),
        .o_set_cpr     (o_set_cpr),
        .o_set_position(o_set_position),
        .o_enable_index(o_enable_index),
        .i_index       (i_index),
        .i_position    (i_position),
        .o_state       (o_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every response must have been predicted by a driver task.
    always @(negedge clk) begin
        if (!rst && o_rsp_valid) begin
            check_eq("rsp_vs_ready", o_cmd_ready, 1'b0);
            check_eq("rsp_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                logic [BW:0] e;
                e = exp_q.pop_front();
                check_eq("rsp_data", o_rsp_data, e[BW-1:0]);
                check_eq("rsp_error", o_rsp_error, e[BW]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Returns at the falling edge of cycle 0 with i_cmd_valid dropped.
    task automatic issue(input logic [1:0] op, input logic [BW-1:0] data);
        int waited;
        @(negedge clk);
        i_cmd_valid = 1'b1;
        i_cmd_op    = op;
        i_cmd_data  = data;
        waited      = 0;
        while (!o_cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check_eq("accept_ready", o_cmd_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        i_cmd_valid = 1'b0;
    endtask

    task automatic run_set(input logic [1:0] op, input logic [BW-1:0] data);
        logic strobe_exp;
        exp_q.push_back({1'b0, data});
        issue(op, data);
        for (int k = 0; k <= 7; k++) begin
            strobe_exp = (k == 2) || (k == 3);
            if (k >= 1) check_eq("set_bus", o_data_bus, data);
            check_eq("set_cpr", o_set_cpr, (op == OP_SET_CPR) && strobe_exp);
            check_eq("set_pos", o_set_position, (op == OP_SET_POS) && strobe_exp);
            check_eq("set_rsp_valid", o_rsp_valid, k == 6);
            check_eq("set_ready", o_cmd_ready, k == 7);
            if (k < 7) @(negedge clk);
        end
    endtask

    task automatic run_home(input bit pre_high);
        int rise_k;
        int done_k;
        exp_q.push_back({1'b0, {BW{1'b0}}});
        if (pre_high) begin
            i_index = 1'b1;
            repeat (4) @(negedge clk);
        end
        rise_k = pre_high ? 14 : 10;
        done_k = rise_k + 3;   // two sync flops plus the detect edge
        issue(OP_HOME, '0);
        for (int k = 0; k <= done_k + 1; k++) begin
            if (pre_high && k == 10) i_index = 1'b0;
            if (k == rise_k) i_index = 1'b1;
            if (k >= 1) check_eq("home_enable", o_enable_index, k < done_k);
            check_eq("home_rsp_valid", o_rsp_valid, k == done_k);
            if (k <= done_k) @(negedge clk);
        end
        i_index = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic run_read_static(input logic [BW-1:0] pos);
        i_position = pos;
        exp_q.push_back({1'b0, pos});
        issue(OP_READ, '0);
        for (int k = 0; k <= 4; k++) begin
            check_eq("read_rsp_valid", o_rsp_valid, k == 3);
            check_eq("read_ready", o_cmd_ready, k == 4);
            if (k < 4) @(negedge clk);
        end
    endtask

    // Position changes every cycle: five sample pairs all disagree. Samples
    // are taken on edges 1,2,4,6,8,10; the last one (edge 10) sees the value
    // driven in cycle 9.
    task automatic run_read_moving(input logic [BW-1:0] base);
        exp_q.push_back({1'b1, base + BW'(9)});
        issue(OP_READ, '0);
        for (int k = 0; k <= 12; k++) begin
            i_position = base + BW'(k);
            check_eq("mread_rsp_valid", o_rsp_valid, k == 11);
            check_eq("mread_ready", o_cmd_ready, k == 12);
            if (k < 12) @(negedge clk);
        end
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst         = 1'b1;
        i_cmd_valid = 1'b0;
        i_cmd_op    = 2'b00;
        i_cmd_data  = '0;
        i_index     = 1'b0;
        i_position  = '0;

        repeat (3) @(negedge clk);
        check_eq("rst_ready", o_cmd_ready, 1'b0);
        check_eq("rst_rsp_valid", o_rsp_valid, 1'b0);
        check_eq("rst_rsp_data", o_rsp_data, '0);
        check_eq("rst_data_bus", o_data_bus, '0);
        check_eq("rst_strobes", {o_set_cpr, o_set_position, o_enable_index}, 3'b000);
        check_eq("rst_state", o_state, 3'd0);
        rst = 1'b0;
        check_eq("rel_ready_before_edge", o_cmd_ready, 1'b0);
        @(negedge clk);
        check_eq("rel_ready_first_edge", o_cmd_ready, 1'b1);

        run_set(OP_SET_CPR, 32'h0000_0FA0);
        check_eq("bus_retained", o_data_bus, 32'h0000_0FA0);
        run_set(OP_SET_POS, $urandom());

        run_home(1'b0);
        run_home(1'b1);

        run_read_static(32'h0000_1234);
        run_read_moving(32'h0000_5000);
        for (int i = 0; i < 3; i++) run_read_static($urandom());
        for (int i = 0; i < 2; i++)
            run_set(($urandom_range(0, 1) == 0) ? OP_SET_CPR : OP_SET_POS, $urandom());

        // Reset while SET_POS strobe is high: aborts without a response.
        issue(OP_SET_POS, 32'hA5A5_0F0F);
        repeat (2) @(negedge clk);
        check_eq("abort_strobe_before", o_set_position, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_set_pos", o_set_position, 1'b0);
        check_eq("abort_data_bus", o_data_bus, '0);
        check_eq("abort_enable", o_enable_index, 1'b0);
        check_eq("abort_ready", o_cmd_ready, 1'b0);
        check_eq("abort_rsp_valid", o_rsp_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_ready_released", o_cmd_ready, 1'b0);
        @(negedge clk);
        check_eq("abort_ready_first_edge", o_cmd_ready, 1'b1);

`ifdef ENCODER_HOME_TIMEOUT_EN
        exp_q.push_back({1'b1, {BW{1'b0}}});
        issue(OP_HOME, '0);
        for (int k = 0; k <= 52; k++) begin
            if (k >= 1) check_eq("to_enable", o_enable_index, k < 50);
            check_eq("to_rsp_valid", o_rsp_valid, k == 50);
            if (k < 52) @(negedge clk);
        end
`else
        // No index edge and no timeout: HOME must stay pending.
        issue(OP_HOME, '0);
        repeat (1000) @(negedge clk);
        check_eq("home_wait_enable", o_enable_index, 1'b1);
        check_eq("home_wait_ready", o_cmd_ready, 1'b0);
        reset_pulse();
        check_eq("home_wait_reset_enable", o_enable_index, 1'b0);
        check_eq("home_wait_reset_ready", o_cmd_ready, 1'b1);
`endif

        repeat (3) @(negedge clk);
        check_eq("sb_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/encoder_cmd_sequencer.md
Name: encoder_cmd_sequencer

Overview:
- Synchronous command front-end for the asynchronous 32-bit incremental encoder counter.
- Turns host commands into safely timed accesses on the counter's shared DataBus/SetCPR/SetPosition/EnableIndex controls: set CPR, set position, index homing and glitch-free position readback.
- Sits between the host register file and one encoder counter instance; one command in flight at a time.

Parameters:
- BUSWIDTH, 32, width of data bus, position and command payload
- SETUP_CYCLES, 2, cycles DataBus is stable before strobe rises (1..255)
- STROBE_CYCLES, 2, cycles SetCPR/SetPosition held high (1..255)
- HOLD_CYCLES, 2, cycles DataBus held after strobe falls (1..255)
- READ_RETRIES, 4, extra sample pairs allowed before a read fails (0..15)
- HOME_TIMEOUT_CYCLES, 1000000, homing timeout (used only with the macro)

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- CmdValid  in  1  command request
- CmdReady  out  1  block idle, command accepted when CmdValid&&CmdReady
- CmdOp  in  2  00 SET_CPR, 01 SET_POS, 10 HOME, 11 READ_POS
- CmdData  in  BUSWIDTH  payload for SET_CPR/SET_POS
- RspValid  out  1  one-cycle completion pulse, no backpressure
- RspData  out  BUSWIDTH  result (written value, 0 for HOME, position for READ_POS)
- RspError  out  1  qualifies RspValid: timeout or unstable read
- DataBus  out  BUSWIDTH  to counter data bus
- SetCPR  out  1  to counter CPR load strobe
- SetPosition  out  1  to counter position load strobe
- EnableIndex  out  1  to counter index enable
- Index  in  1  raw index channel I (asynchronous)
- Position  in  BUSWIDTH  counter position (asynchronous to Clock)

Behaviour:
- Reset (async): state IDLE; CmdReady=0, RspValid=0, RspError=0, RspData=0, DataBus=0, SetCPR=0, SetPosition=0, EnableIndex=0; sync flops and counters cleared. CmdReady goes 1 on the first Clock edge after Reset deasserts. Reset mid-command aborts immediately, with no response.
- States: IDLE, SETUP, STROBE, HOLD, HOME_WAIT, READ_A, READ_B, RESP.
- IDLE: CmdReady=1. On accept (cycle 0), register op and data and drop CmdReady. CmdReady is 0 in every other state.
- SET_CPR/SET_POS:
  - DataBus<=CmdData at the accept edge.
  - SETUP lasts SETUP_CYCLES cycles.
  - STROBE raises the selected strobe for STROBE_CYCLES cycles; the other strobe stays 0.
  - HOLD lasts HOLD_CYCLES cycles with DataBus unchanged.
  - RESP asserts RspValid for 1 cycle with RspData=CmdData and RspError=0, then returns to IDLE.
  - Defaults: strobe high in cycles 2–3, RspValid in cycle 6, CmdReady in cycle 7.
  - DataBus retains its last value after the command.
- HOME:
  - EnableIndex=1 from cycle 1.
  - Index passes through a 2-flop synchronizer; a rising edge of the synchronized signal (0→1 between consecutive samples) completes homing. The counter zeroes itself on the raw edge.
  - On detect, EnableIndex<=0, then RESP with RspData=0 and RspError=0.
  - Index already high at accept is not a valid edge; a new 0→1 transition is required.
- READ_POS:
  - READ_A captures Position into S0 at edge 1; READ_B captures into S1 at edge 2.
  - If S0==S1: RESP with RspData=S1, RspError=0. RspValid in cycle 3.
  - If S0!=S1: S0<=S1, retry counter increments, and READ_B repeats. After READ_RETRIES failed retries: RESP with RspData=last S1, RspError=1.
- CmdValid while busy is ignored. The requester must hold the command until CmdReady.
- RspValid is never asserted in the same cycle as CmdReady.

Optional Feature:
- Macro: ENCODER_HOME_TIMEOUT_EN.
- Defined: a cycle counter runs in HOME_WAIT. If HOME_TIMEOUT_CYCLES elapse without an index edge, EnableIndex<=0, then RESP with RspData=0 and RspError=1. An edge arriving in the same cycle as expiry counts as success.
- Undefined: HOME_WAIT waits indefinitely, only Reset exits, and no timeout counter is built.

Test Plan:
- Reset released, SET_CPR 0x00000FA0 with defaults:
  - DataBus=0x00000FA0 from cycle 1 on.
  - SetCPR high exactly cycles 2–3; SetPosition stays 0.
  - RspValid cycle 6 with RspData=0x00000FA0 and RspError=0.
  - CmdReady high again in cycle 7.
- HOME, raw Index rising 10 cycles after accept:
  - EnableIndex high from cycle 1.
  - EnableIndex drops 2–3 cycles after the edge.
  - RspValid with RspData=0 and RspError=0.
  - Same test with Index held high at accept: no completion until Index goes low then high.
- READ_POS with Position static at 0x00001234: RspValid cycle 3, RspData=0x00001234, RspError=0.
- READ_POS with Position changing every cycle: after 1+READ_RETRIES pairs (default 5), RspError=1 and RspData equals the last sample.
- Reset asserted during STROBE of SET_POS: SetPosition, DataBus and EnableIndex go 0 immediately; no RspValid; CmdReady=1 on the first edge after release.
- With ENCODER_HOME_TIMEOUT_EN and HOME_TIMEOUT_CYCLES=50, no index edge: RspError=1 and EnableIndex=0 about 50 cycles after accept. Without the macro, no response after 1000 cycles.
